// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath widths, register index/word types and $0 index
package mips_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: index mux, $0 masking, optional bypass (REGFILE_BYPASS_EN)
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]                 read_addr_i,
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] regs_flat_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                                  byp_valid_i,
  input  logic [ADDR_WIDTH-1:0]                 byp_addr_i,
  input  logic [DATA_WIDTH-1:0]                 byp_data_i,
`endif
  output logic [DATA_WIDTH-1:0]                 read_data_o
);

  // Select the addressed word, let an in-flight write win, and force $0 to zero last
  always_comb begin
    read_data_o = regs_flat_i[read_addr_i*DATA_WIDTH +: DATA_WIDTH];
`ifdef REGFILE_BYPASS_EN
    if (byp_valid_i && (byp_addr_i == read_addr_i)) begin
      read_data_o = byp_data_i;
    end
`endif
    if (read_addr_i == ADDR_WIDTH'(REG_ZERO)) begin
      read_data_o = '0;
    end
  end

endmodule

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - 32x32 MIPS register file, two read ports, one write port; REGFILE_BYPASS_EN enables write-to-read forwarding
module mips_register_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [31:0]           write_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  // $0 has no storage; index 0 of the flat bus is tied to zero instead
  logic [DATA_WIDTH-1:0]       regs_q [1:DEPTH-1];
  logic [DATA_WIDTH-1:0]       regs_d [1:DEPTH-1];
  logic [DEPTH*DATA_WIDTH-1:0] regs_flat;
  logic [31:0]                 write_count_q;
  logic [31:0]                 write_count_d;
  logic                        wr_hit;

  assign wr_hit = write_enable && (write_addr != ADDR_WIDTH'(REG_ZERO));

  // Write decode: only the addressed nonzero register takes the new word
  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = (wr_hit && (write_addr == ADDR_WIDTH'(i))) ? write_data : regs_q[i];
    end
    write_count_d = wr_hit ? (write_count_q + 32'd1) : write_count_q;
  end

  // Storage and write counter; reset clears everything without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      write_count_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      write_count_q <= write_count_d;
    end
  end

  assign regs_flat[DATA_WIDTH-1:0] = '0;
  for (genvar g = 1; g < DEPTH; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign write_count = write_count_q;

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so reads stay zero while rst_n is low
  logic byp_valid;
  assign byp_valid = wr_hit && rst_n;
`endif

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port_a (
    .read_addr_i (read_addr_a),
    .regs_flat_i (regs_flat),
`ifdef REGFILE_BYPASS_EN
    .byp_valid_i (byp_valid),
    .byp_addr_i  (write_addr),
    .byp_data_i  (write_data),
`endif
    .read_data_o (read_data_a)
  );

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port_b (
    .read_addr_i (read_addr_b),
    .regs_flat_i (regs_flat),
`ifdef REGFILE_BYPASS_EN
    .byp_valid_i (byp_valid),
    .byp_addr_i  (write_addr),
    .byp_data_i  (write_data),
`endif
    .read_data_o (read_data_b)
  );

`ifndef SYNTHESIS
  // An unknown write index with the port enabled would corrupt an arbitrary register
  always @(posedge clk) begin
    if (rst_n && write_enable) begin
      assert (!$isunknown(write_addr));
    end
  end
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// tb/tb_mips_register_file.sv - table-driven self-checking bench for mips_register_file
module tb_mips_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_addr_a;
  logic [4:0]  read_addr_b;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] write_count;

  int passed;
  int total;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ec;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  mips_register_file dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_addr_a  (read_addr_a),
    .read_addr_b  (read_addr_b),
    .read_data_a  (read_data_a),
    .read_data_b  (read_data_b),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_count  (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [31:0] xor_res;
    passed = 0;
    total  = 0;

    // Vectors: inputs driven at negedge, reads/count checked before the following posedge commit
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,
                 BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'd0};
    vecs[1]  = '{1'b1, 5'd31, 32'h0F0F0F0F, 5'd5, 5'd31,
                 32'hDEADBEEF, BYP ? 32'h0F0F0F0F : 32'h0, 32'd1};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd31,
                 32'hDEADBEEF, 32'h0F0F0F0F, 32'd2};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,
                 32'h0, 32'h0, 32'd2};
    vecs[4]  = '{1'b0, 5'd7,  32'h12345678, 5'd0, 5'd0,
                 32'h0, 32'h0, 32'd2};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd7,
                 32'h0, 32'h0, 32'd2};
    vecs[6]  = '{1'b1, 5'd9,  32'h11111111, 5'd5, 5'd5,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'd2};
    vecs[7]  = '{1'b1, 5'd9,  32'h22222222, 5'd9, 5'd31,
                 BYP ? 32'h22222222 : 32'h11111111, 32'h0F0F0F0F, 32'd3};
    vecs[8]  = '{1'b1, 5'd1,  32'hAAAA5555, 5'd9, 5'd9,
                 32'h22222222, 32'h22222222, 32'd4};
    vecs[9]  = '{1'b1, 5'd2,  32'hFFFF0000, 5'd1, 5'd0,
                 32'hAAAA5555, 32'h0, 32'd5};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd1, 5'd2,
                 32'hAAAA5555, 32'hFFFF0000, 32'd6};

    // Power-on reset state
    rst_n        = 1'b0;
    write_enable = 1'b0;
    write_addr   = 5'd0;
    write_data   = 32'h0;
    read_addr_a  = 5'd5;
    read_addr_b  = 5'd31;
    #1;
    chk("por_read_a", read_data_a, 32'h0);
    chk("por_read_b", read_data_b, 32'h0);
    chk("por_count",  write_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      write_enable = vecs[i].we;
      write_addr   = vecs[i].wa;
      write_data   = vecs[i].wd;
      read_addr_a  = vecs[i].ra;
      read_addr_b  = vecs[i].rb;
      #1;
      chk($sformatf("vec%0d_read_a", i), read_data_a, vecs[i].ea);
      chk($sformatf("vec%0d_read_b", i), read_data_b, vecs[i].eb);
      chk($sformatf("vec%0d_count", i),  write_count, vecs[i].ec);
    end

    // ALU hookup: XOR of r1 and r2 written back to r3
    @(negedge clk);
    write_enable = 1'b0;
    read_addr_a  = 5'd1;
    read_addr_b  = 5'd2;
    #1;
    xor_res = read_data_a ^ read_data_b;
    chk("alu_xor", xor_res, 32'h55555555);
    write_enable = 1'b1;
    write_addr   = 5'd3;
    write_data   = xor_res;
    @(negedge clk);
    write_enable = 1'b0;
    read_addr_a  = 5'd3;
    read_addr_b  = 5'd9;
    #1;
    chk("xor_wb_r3", read_data_a, 32'h55555555);
    chk("hazard_next_r9", read_data_b, 32'h22222222);
    chk("xor_wb_count", write_count, 32'd7);

    // Mid-cycle reset with a pending write to r4: the write must be lost
    @(negedge clk);
    write_enable = 1'b1;
    write_addr   = 5'd4;
    write_data   = 32'hCAFEF00D;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_count", write_count, 32'd0);
    for (int a = 0; a < 32; a++) begin
      read_addr_a = 5'(a);
      read_addr_b = 5'(31 - a);
      #1;
      chk($sformatf("rst_read_a%0d", a), read_data_a, 32'h0);
      chk($sformatf("rst_read_b%0d", 31 - a), read_data_b, 32'h0);
    end

    // Release reset and write on the very first edge afterwards
    @(negedge clk);
    rst_n        = 1'b1;
    write_enable = 1'b1;
    write_addr   = 5'd6;
    write_data   = 32'h13579BDF;
    read_addr_a  = 5'd4;
    read_addr_b  = 5'd4;
    #1;
    chk("lost_write_r4", read_data_a, 32'h0);
    chk("post_rst_count0", write_count, 32'd0);
    @(negedge clk);
    write_enable = 1'b0;
    read_addr_a  = 5'd6;
    read_addr_b  = 5'd6;
    #1;
    chk("first_write_a", read_data_a, 32'h13579BDF);
    chk("first_write_b", read_data_b, 32'h13579BDF);
    chk("first_write_count", write_count, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
